// File: rtl/ysyx_lsu_pkg.sv
// Shared LSU definitions: data width, timeout default, FSM states and func3 size codes.
package ysyx_lsu_pkg;

  localparam int YSYX_W_WIDTH     = 32;
  localparam int YSYX_LSU_TIMEOUT = 255;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // func3 encodings; bit 2 selects zero extension, bits 1:0 the access size.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (func3[1:0])
      2'b01:   mis = offset[0];
      2'b10:   mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_lsu_if.sv
// Memory-side bus of the LSU.
// Handshake: the master raises bus_valid_o with all request fields and holds them
// stable until it samples bus_ready_i high on a rising edge; bus_rdata_i and bus_err_i
// are valid in that same cycle. The master may drop bus_valid_o without ready only on
// timeout or reset, and the slave must tolerate that.
interface ysyx_lsu_if import ysyx_lsu_pkg::*; #(
  parameter int BIT_W = YSYX_W_WIDTH
);
  logic               bus_valid_o;
  logic               bus_we_o;
  logic [BIT_W-1:0]   bus_addr_o;
  logic [BIT_W-1:0]   bus_wdata_o;
  logic [BIT_W/8-1:0] bus_wstrb_o;
  logic               bus_ready_i;
  logic [BIT_W-1:0]   bus_rdata_i;
  logic               bus_err_i;

  modport master (
    output bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
    input  bus_ready_i, bus_rdata_i, bus_err_i
  );

  modport slave (
    input  bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
    output bus_ready_i, bus_rdata_i, bus_err_i
  );
endinterface

// File: rtl/ysyx_lsu_align.sv
// Load extraction: shift the selected bytes down to bit 0 and extend per func3.
module ysyx_lsu_align import ysyx_lsu_pkg::*; #(
  parameter int BIT_W = YSYX_W_WIDTH
) (
  input  logic [BIT_W-1:0] word,
  input  logic [1:0]       offset,
  input  logic [2:0]       func3,
  output logic [BIT_W-1:0] data
);

  logic [BIT_W-1:0] shifted;

  // Right-justify the addressed lane, then sign or zero extend by size.
  always_comb begin
    shifted = word >> {offset, 3'b000};
    data    = shifted;
    case (func3[1:0])
      2'b00:   data = {{(BIT_W-8){~func3[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   data = {{(BIT_W-16){~func3[2] & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: one outstanding EXU request, IDLE -> REQ -> DONE -> IDLE,
// with byte-lane steering, misalignment rejection and a bus wait timeout.
module ysyx_lsu import ysyx_lsu_pkg::*; #(
  parameter int BIT_W   = YSYX_W_WIDTH,
  parameter int TIMEOUT = YSYX_LSU_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_avalid,
  input  logic [BIT_W-1:0] lsu_addr,
  input  logic [BIT_W-1:0] lsu_wdata,
  input  logic             lsu_ren,
  input  logic             lsu_wen,
  input  logic [2:0]       lsu_func3,
  output logic [BIT_W-1:0] lsu_rdata_o,
  output logic             lsu_rvalid_o,
  output logic             lsu_wready_o,
  output logic             lsu_err_o,
  output lsu_state_e       dbg_state,
  ysyx_lsu_if.master       bus
);

  localparam int SW    = BIT_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e       state;
  lsu_state_e       state_next;
  logic [BIT_W-1:0] addr_q;
  logic [BIT_W-1:0] wdata_q;
  logic [2:0]       func3_q;
  logic             we_q;
  logic             err_q;
  logic [BIT_W-1:0] rdata_q;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] align_data;
  logic             accept;
  logic             misaligned;
  logic             timeout_hit;

  assign accept      = lsu_avalid & (lsu_ren | lsu_wen);
  assign misaligned  = is_misaligned(lsu_func3, lsu_addr[1:0]);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  ysyx_lsu_align #(.BIT_W(BIT_W)) u_align (
    .word   (bus.bus_rdata_i),
    .offset (addr_q[1:0]),
    .func3  (func3_q),
    .data   (align_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= LSU_IDLE;
    else      state <= state_next;
  end

  // Next-state: misaligned requests skip the bus; ready beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE: if (accept) state_next = misaligned ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (bus.bus_ready_i || timeout_hit) state_next = LSU_DONE;
      LSU_DONE: state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  // Request latch, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      cnt <= '0;
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            addr_q  <= lsu_addr;
            wdata_q <= lsu_wdata;
            func3_q <= lsu_func3;
            we_q    <= lsu_wen;
            err_q   <= misaligned;
            if (misaligned) rdata_q <= '0;
          end
        end
        LSU_REQ: begin
          if (bus.bus_ready_i) begin
            err_q   <= bus.bus_err_i;
            rdata_q <= we_q ? '0 : align_data;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: bus fields come straight from the latched request so they stay stable in REQ.
  always_comb begin
    bus.bus_valid_o = (state == LSU_REQ);
    bus.bus_we_o    = we_q;
    bus.bus_addr_o  = {addr_q[BIT_W-1:2], 2'b00};
    bus.bus_wdata_o = wdata_q << {addr_q[1:0], 3'b000};
    case (func3_q[1:0])
      2'b00:   bus.bus_wstrb_o = SW'(1) << addr_q[1:0];
      2'b01:   bus.bus_wstrb_o = SW'(3) << addr_q[1:0];
      default: bus.bus_wstrb_o = '1;
    endcase
    lsu_rvalid_o = (state == LSU_DONE) & ~we_q;
    lsu_wready_o = (state == LSU_DONE) & we_q;
    lsu_err_o    = (state == LSU_DONE) & err_q;
    lsu_rdata_o  = rdata_q;
    dbg_state    = state;
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed and randomized checks of ysyx_lsu against a byte-lane reference model.
module tb_ysyx_lsu;
  import ysyx_lsu_pkg::*;

  localparam int T2 = 4;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        avalid, avalid2, ren, wen;
  logic [31:0] addr, wdata;
  logic [2:0]  func3;
  logic [31:0] rdata, rdata2;
  logic        rvalid, wready, err, rvalid2, wready2, err2;
  lsu_state_e  st, st2;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  ysyx_lsu_if #(.BIT_W(32)) bus ();
  ysyx_lsu_if #(.BIT_W(32)) bus2 ();

  ysyx_lsu #(.BIT_W(32)) dut (
    .clk(clk), .rst(rst), .lsu_avalid(avalid), .lsu_addr(addr), .lsu_wdata(wdata),
    .lsu_ren(ren), .lsu_wen(wen), .lsu_func3(func3), .lsu_rdata_o(rdata),
    .lsu_rvalid_o(rvalid), .lsu_wready_o(wready), .lsu_err_o(err),
    .dbg_state(st), .bus(bus)
  );

  // Second instance with a short timeout; its memory never answers.
  ysyx_lsu #(.BIT_W(32), .TIMEOUT(T2)) dut_to (
    .clk(clk), .rst(rst), .lsu_avalid(avalid2), .lsu_addr(addr), .lsu_wdata(wdata),
    .lsu_ren(ren), .lsu_wen(wen), .lsu_func3(func3), .lsu_rdata_o(rdata2),
    .lsu_rvalid_o(rvalid2), .lsu_wready_o(wready2), .lsu_err_o(err2),
    .dbg_state(st2), .bus(bus2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes.
  function automatic int size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Reference model: load value assembled from the memory word's bytes.
  function automatic logic [31:0] model_load(input logic [31:0] word, input int a, input logic [2:0] f3);
    logic [7:0] b[4];
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    case (f3)
      3'b000:  return {{24{b[a][7]}}, b[a]};
      3'b100:  return {24'h0, b[a]};
      3'b001:  return {{16{b[a+1][7]}}, b[a+1], b[a]};
      3'b101:  return {16'h0, b[a+1], b[a]};
      default: return word;
    endcase
  endfunction

  // One request through dut (sel=0) or dut_to (sel=1); delay<0 means memory never answers.
  task automatic txn(input int sel, input bit we, input logic [31:0] a_in, input logic [31:0] wd,
                     input logic [2:0] f3, input int delay, input logic [31:0] word,
                     input bit berr, input string tag);
    int ai, n, vcount, pulse_c, unstable, exp_pulse, exp_vcount;
    bit mis, done, tmo, v;
    logic [31:0] f_addr, f_wdata, c_addr, c_wdata, exp_rd, got_rd, exp_wd;
    logic [3:0]  f_strb, c_strb, exp_strb;
    logic        f_we, c_we, pr, pw, pe, got_err, exp_err;
    logic [1:0]  got_kind;
    ai = int'(a_in % 4);
    n = size_bytes(f3);
    mis = (ai % n) != 0;
    tmo = !mis && delay < 0;
    exp_err = mis || tmo || berr;
    exp_pulse = mis ? 1 : (tmo ? T2 + 1 : delay + 2);
    exp_vcount = mis ? 0 : (tmo ? T2 : delay + 1);
    exp_rd = (we || mis || tmo) ? 32'h0 : model_load(word, ai, f3);
    exp_wd = wd << (8 * ai);
    for (int i = 0; i < 4; i++) exp_strb[i] = (i >= ai) && (i < ai + n);
    exp_q.push_back(exp_rd);
    vcount = 0; pulse_c = -1; unstable = 0; done = 0;
    got_err = 1'b0; got_rd = 32'h0; got_kind = 2'b00;
    f_addr = '0; f_wdata = '0; f_strb = '0; f_we = 1'b0;
    @(negedge clk);
    addr = a_in; wdata = wd; func3 = f3; ren = !we; wen = we;
    if (sel == 0) avalid = 1'b1; else avalid2 = 1'b1;
    for (int c = 1; c <= 300 && !done; c++) begin
      @(negedge clk);
      v       = (sel == 0) ? bus.bus_valid_o : bus2.bus_valid_o;
      c_addr  = (sel == 0) ? bus.bus_addr_o  : bus2.bus_addr_o;
      c_wdata = (sel == 0) ? bus.bus_wdata_o : bus2.bus_wdata_o;
      c_strb  = (sel == 0) ? bus.bus_wstrb_o : bus2.bus_wstrb_o;
      c_we    = (sel == 0) ? bus.bus_we_o    : bus2.bus_we_o;
      if (v) begin
        if (vcount == 0) begin
          f_addr = c_addr; f_wdata = c_wdata; f_strb = c_strb; f_we = c_we;
        end else if ({c_addr, c_wdata, c_strb, c_we} !== {f_addr, f_wdata, f_strb, f_we}) begin
          unstable++;
        end
        vcount++;
      end
      pr = (sel == 0) ? rvalid : rvalid2;
      pw = (sel == 0) ? wready : wready2;
      pe = (sel == 0) ? err    : err2;
      if (pr || pw) begin
        pulse_c = c; done = 1; got_err = pe; got_kind = {pr, pw};
        got_rd = (sel == 0) ? rdata : rdata2;
      end
      if (sel == 0) begin
        bus.bus_ready_i = v && (vcount - 1 == delay);
        bus.bus_rdata_i = word;
        bus.bus_err_i   = berr;
      end
    end
    avalid = 1'b0; avalid2 = 1'b0; bus.bus_ready_i = 1'b0;
    exp_rd = exp_q.pop_front();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cycle"}, pulse_c, exp_pulse);
    check({tag, "_kind"}, {30'h0, got_kind}, we ? 32'd1 : 32'd2);
    check({tag, "_err"}, {31'h0, got_err}, {31'h0, exp_err});
    if (!tmo) check({tag, "_rdata"}, got_rd, exp_rd);
    check({tag, "_vcount"}, vcount, exp_vcount);
    if (vcount > 0) begin
      check({tag, "_addr"}, f_addr, a_in - 32'(ai));
      check({tag, "_we"}, {31'h0, f_we}, {31'h0, we});
      check({tag, "_stable"}, unstable, 0);
      if (we) begin
        check({tag, "_wdata"}, f_wdata, exp_wd);
        check({tag, "_wstrb"}, {28'h0, f_strb}, {28'h0, exp_strb});
      end
    end
    @(negedge clk);
    pr = (sel == 0) ? rvalid : rvalid2;
    pw = (sel == 0) ? wready : wready2;
    check({tag, "_single_pulse"}, {30'h0, pr, pw}, 32'd0);
  endtask

  initial begin
    logic [2:0] f3_tab[5];
    logic [2:0] f3r;
    bit         wr;
    f3_tab[0] = F3_B; f3_tab[1] = F3_H; f3_tab[2] = F3_W; f3_tab[3] = F3_BU; f3_tab[4] = F3_HU;
    avalid = 0; avalid2 = 0; ren = 0; wen = 0; addr = 0; wdata = 0; func3 = 0;
    bus.bus_ready_i = 0; bus.bus_rdata_i = 0; bus.bus_err_i = 0;
    bus2.bus_ready_i = 0; bus2.bus_rdata_i = 0; bus2.bus_err_i = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_valid", {31'h0, bus.bus_valid_o}, 32'd0);
    check("reset_pulses", {29'h0, rvalid, wready, err}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b1;

    // Directed cases.
    txn(0, 0, 32'h8000_0004, 32'h0, F3_W, 0, 32'hDEAD_BEEF, 0, "lw_basic");
    repeat (3) @(negedge clk);
    check("rdata_hold", rdata, 32'hDEAD_BEEF);
    txn(0, 0, 32'h8000_0003, 32'h0, F3_B, 0, 32'h8011_2233, 0, "lb_sign");
    txn(0, 0, 32'h8000_0003, 32'h0, F3_BU, 1, 32'h8011_2233, 0, "lbu_zero");
    txn(0, 1, 32'h8000_0002, 32'h0000_ABCD, F3_H, 5, 32'h0, 0, "sh_delay");
    txn(0, 0, 32'h8000_0001, 32'h0, F3_W, 0, 32'h1234_5678, 0, "lw_misaligned");
    txn(0, 0, 32'h8000_0002, 32'h0, F3_HU, 2, 32'hF00D_CAFE, 1, "lhu_buserr");
    txn(1, 0, 32'h8000_0008, 32'h0, F3_W, -1, 32'h0, 0, "lw_timeout");

    // Reset in the middle of a bus wait.
    txn(0, 0, 32'h8000_0000, 32'h0, F3_W, 0, 32'h7777_1111, 0, "lw_prerst");
    @(negedge clk);
    addr = 32'h8000_0008; func3 = F3_W; ren = 1; wen = 0; avalid = 1;
    repeat (3) @(negedge clk);
    check("rst_pre_valid", {31'h0, bus.bus_valid_o}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'h0, bus.bus_valid_o}, 32'd0);
    check("rst_mid_pulses", {29'h0, rvalid, wready, err}, 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_state", 32'(st), 32'(LSU_IDLE));
    avalid = 0;
    @(negedge clk);
    rst = 1'b1;
    txn(0, 0, 32'h8000_000C, 32'h0, F3_W, 0, 32'h0BAD_F00D, 0, "lw_after_rst");

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      wr  = $urandom_range(0, 1);
      f3r = wr ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 4)];
      txn(0, wr, 32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom, f3r,
          $urandom_range(0, 5), $urandom, $urandom_range(0, 7) == 0, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_lsu.md
YSYX_LSU -- requirements
Module: ysyx_lsu

Interface
REQ-001 SHALL have parameter BIT_W, default `YSYX_W_WIDTH (32), the data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum bus wait cycles before an error response.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-low reset.
REQ-005 SHALL have port lsu_avalid  input  1  EXU request valid, held high until the response pulse.
REQ-006 SHALL have port lsu_addr  input  BIT_W  byte address (EXU rwaddr).
REQ-007 SHALL have port lsu_wdata  input  BIT_W  store data, right-justified.
REQ-008 SHALL have port lsu_ren  input  1  request is a load.
REQ-009 SHALL have port lsu_wen  input  1  request is a store.
REQ-010 SHALL have port lsu_func3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 SHALL have port lsu_rdata_o  output  BIT_W  load result, extended per func3.
REQ-012 SHALL have port lsu_rvalid_o  output  1  one-cycle load-done pulse.
REQ-013 SHALL have port lsu_wready_o  output  1  one-cycle store-done pulse.
REQ-014 SHALL have port lsu_err_o  output  1  bus error or timeout; valid with the done pulse.
REQ-015 SHALL have port bus_valid_o  output  1  memory request valid.
REQ-016 SHALL have port bus_we_o  output  1  memory request is a write.
REQ-017 SHALL have port bus_addr_o  output  BIT_W  word-aligned address (addr[1:0] forced to 0).
REQ-018 SHALL have port bus_wdata_o  output  BIT_W  lane-shifted write data.
REQ-019 SHALL have port bus_wstrb_o  output  BIT_W/8  byte-lane strobes.
REQ-020 SHALL have port bus_ready_i  input  1  memory completion; rdata valid in the same cycle.
REQ-021 SHALL have port bus_rdata_i  input  BIT_W  read word.
REQ-022 SHALL have port bus_err_i  input  1  memory error, qualified by bus_ready_i.

Function
REQ-023 SHALL implement FSM IDLE -> REQ -> DONE -> IDLE.
REQ-024 IDLE: on lsu_avalid & (lsu_ren|lsu_wen), SHALL latch addr, wdata, func3 and we = lsu_wen, then enter REQ next cycle.
REQ-025 If lsu_ren and lsu_wen are both high, the request SHALL be treated as a store.
REQ-026 REQ: bus_valid_o SHALL be high and all bus outputs SHALL be stable until bus_ready_i.
REQ-027 On bus_ready_i in REQ, SHALL capture rdata and err, drop bus_valid_o and enter DONE.
REQ-028 Timeout counter SHALL reset to 0 on entering REQ and increment each REQ cycle without ready.
REQ-029 On reaching TIMEOUT, SHALL drop bus_valid_o, set err, and enter DONE.
REQ-030 DONE: exactly one cycle of lsu_rvalid_o (load) or lsu_wready_o (store), then IDLE.
REQ-031 IDLE SHALL NOT accept a request in the DONE cycle; minimum latency is request to pulse = 3 cycles with ready in the first REQ cycle.
REQ-032 Store lanes: wdata SHALL be shifted left by 8*addr[1:0]; wstrb SHALL be B 0001<<a, H 0011<<a, W 1111.
REQ-033 Load: the word SHALL be shifted right by 8*addr[1:0]; B/H SHALL be sign-extended; BU/HU SHALL be zero-extended.
REQ-034 Misaligned access (H at a[0]=1, W at a[1:0]!=0) SHALL issue no bus request; DONE SHALL follow IDLE directly with err=1 and rdata=0.
REQ-035 lsu_rdata_o SHALL hold its value until the next load completes; it is 0 for stores.

Reset
REQ-036 While rst=0: FSM to IDLE, counter to 0; bus_valid_o, lsu_rvalid_o, lsu_wready_o and lsu_err_o to 0; lsu_rdata_o to 0.
REQ-037 Reset during REQ SHALL abandon the transfer with no done pulse; the memory side SHALL tolerate bus_valid_o dropping.

Structure
REQ-038 FSM state enum, func3 size encodings and TIMEOUT default SHALL live in the shared ysyx package/header.
REQ-039 Load extraction and sign extension SHALL be a combinational sub-module ysyx_lsu_align; the FSM stays in ysyx_lsu.

Verification
REQ-040 LW addr 0x80000004, mem word 0xDEADBEEF, ready on first REQ cycle -> bus_addr 0x80000004, rvalid pulse 3 cycles after avalid, rdata 0xDEADBEEF, err 0.
REQ-041 LB addr 0x80000003, word 0x80112233 -> rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-042 SH addr 0x80000002, wdata 0x0000ABCD, ready delayed 5 cycles -> wdata 0xABCD0000, wstrb 1100 stable 6 cycles, one wready pulse.
REQ-043 LW addr 0x80000001 -> no bus_valid_o, rvalid with err=1, rdata 0.
REQ-044 TIMEOUT=4, ready never asserted -> bus_valid_o drops after 4 REQ cycles, rvalid with err=1.
REQ-045 rst=0 mid-REQ -> next cycle all outputs 0, no pulse; a following LW completes normally.
